// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
// Imported by apb_rr_arbiter and apb_master_arbiter.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first request above
// last_gnt with wrap-around, as one-hot and as an index.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // one spare bit so last_gnt + N_REQ never overflows
  logic [IDX_W:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = {1'b0, last_gnt} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N_REQ))
        pos = pos - (IDX_W+1)'(N_REQ);
      if (!any && req[pos[IDX_W-1:0]]) begin
        any     = 1'b1;
        gnt_idx = pos[IDX_W-1:0];
      end
    end
    gnt[gnt_idx] = any;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between N_REQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait states.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  req_strb,
  output logic [N_REQ-1:0]           req_gnt,
  output logic [N_REQ-1:0]           req_done,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_W-1:0]          paddr,
  output logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W/8-1:0]        pstrb,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_w(N_REQ);

  apb_state_t state, state_n;

  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] cur_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             load;
  logic             finish;
  logic             abort;
  logic [N_REQ-1:0] done_vec;

  logic [ADDR_W-1:0] addr_a [N_REQ];
  logic [DATA_W-1:0] data_a [N_REQ];
  logic [STRB_W-1:0] strb_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_a[g] = req_wdata[g*DATA_W +: DATA_W];
    assign strb_a[g] = req_strb[g*STRB_W +: STRB_W];
  end

  apb_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .any      (arb_any)
  );

  // no grant is offered while reset is held
  assign load     = (state == IDLE) && arb_any && !preset;
  assign req_gnt  = load ? arb_gnt : '0;
  assign psel     = (state != IDLE);
  assign penable  = (state == ACCESS);
  assign done_vec = N_REQ'(1) << cur_idx;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)
      to_cnt <= '0;
    else if (state == SETUP)
      to_cnt <= '0;
    else if (state == ACCESS && !pready)
      to_cnt <= to_cnt + 1'b1;
  end

  assign abort = (state == ACCESS) && !pready &&
                 (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYC != 0);
  assign abort      = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load)
          state_n = SETUP;
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (pready) begin
          finish  = 1'b1;
          state_n = IDLE;
        end else if (abort) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      last_gnt  <= IDX_W'(N_REQ - 1);
      cur_idx   <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_done <= '0;
      if (load) begin
        last_gnt <= arb_idx;
        cur_idx  <= arb_idx;
        pwrite   <= req_write[arb_idx];
        paddr    <= addr_a[arb_idx];
        pwdata   <= data_a[arb_idx];
        pstrb    <= req_write[arb_idx] ? strb_a[arb_idx] : '0;
      end
      if (finish) begin
        req_done  <= done_vec;
        rsp_rdata <= pwrite ? '0 : prdata;
        rsp_err   <= pslverr;
      end else if (abort) begin
        req_done  <= done_vec;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter with a transaction-level
// model of grants, APB phases and completions.
module tb_apb_master_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            pclk = 1'b0;
  logic            preset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N-1:0]    req_gnt;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .N_REQ       (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_gnt   (req_gnt),
    .req_done  (req_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pending requests per requester
  bit            pend   [N];
  bit            p_wr   [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  logic [SW-1:0] p_strb [N];

  // transfer in flight: age = cycles since its grant
  bit            busy;
  int            age;
  int            owner;
  int            last;
  int            prev_grant;
  bit            prev_done;
  bit            c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic [SW-1:0] c_strb;
  logic [DW-1:0] e_rdata;
  bit            e_err;
  bit            fill_all;
  bit            stall;

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (pend[i])
        return i;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_write[i]           = p_wr[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_wdata[i*DW +: DW]  = p_data[i];
      req_strb[i*SW +: SW]   = p_strb[i];
    end
  endtask

  task automatic step();
    logic [N-1:0]  exp_done;
    logic [N-1:0]  exp_gnt;
    logic [36:0]   exp_bus;
    int            win;
    @(posedge pclk);
    #1;
    exp_done = '0;
    if (prev_done) begin
      exp_done[owner] = 1'b1;
      busy = 1'b0;
    end else if (busy) begin
      age++;
    end
    if (prev_grant >= 0) begin
      busy = 1'b1;
      age  = 1;
    end
    prev_grant = -1;
    prev_done  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (fill_all || $urandom_range(0, 3) == 0)) begin
        pend[i]   = 1'b1;
        p_wr[i]   = 1'($urandom_range(0, 1));
        p_addr[i] = AW'($urandom_range(0, 15) * 4);
        p_data[i] = $urandom;
        p_strb[i] = SW'($urandom_range(0, 15));
      end
    end
    drive_reqs();
    pready  = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
    prdata  = $urandom;
    pslverr = ($urandom_range(0, 3) == 0);
    #1;
    win = busy ? -1 : pick();
    exp_gnt = '0;
    if (win >= 0)
      exp_gnt[win] = 1'b1;
    chk("req_gnt", req_gnt, exp_gnt);
    chk("req_done", req_done, exp_done);
    if (exp_done != '0) begin
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", rsp_err, e_err);
    end
    chk("psel", psel, busy);
    chk("penable", penable, busy && age >= 2);
    if (busy) begin
      exp_bus = {c_wr, (c_wr ? c_strb : SW'(0)), c_addr};
      chk("pwrite_pstrb_paddr", {pwrite, pstrb, paddr}, exp_bus);
      chk("pwdata", pwdata, c_data);
    end
    if (win >= 0) begin
      prev_grant = win;
      last       = win;
      owner      = win;
      pend[win]  = 1'b0;
      c_wr       = p_wr[win];
      c_addr     = p_addr[win];
      c_data     = p_data[win];
      c_strb     = p_strb[win];
    end
    if (busy && age >= 2) begin
      if (pready) begin
        prev_done = 1'b1;
        e_rdata   = c_wr ? '0 : prdata;
        e_err     = pslverr;
      end
`ifdef APB_TIMEOUT_EN
      else if (age == TO + 1) begin
        prev_done = 1'b1;
        e_rdata   = '0;
        e_err     = 1'b1;
      end
`endif
    end
  endtask

  task automatic model_reset();
    busy       = 1'b0;
    age        = 0;
    owner      = 0;
    last       = N - 1;
    prev_grant = -1;
    prev_done  = 1'b0;
    for (int i = 0; i < N; i++)
      pend[i] = 1'b0;
  endtask

  // assert reset in the middle of an ACCESS cycle
  task automatic rst_mid();
    for (int k = 0; k < 50 && !(busy && age >= 2); k++)
      step();
    chk("rst_window_psel", psel, 1'b1);
    #1 preset = 1'b1;
    #1;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_done", req_done, '0);
    chk("rst_gnt", req_gnt, '0);
    model_reset();
    drive_reqs();
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    fill_all = 1'b1;
    step();
    fill_all = 1'b0;
    chk("rst_first_gnt", req_gnt, N'(1));
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = '1;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    fill_all  = 1'b0;
    stall     = 1'b0;
    c_wr      = 1'b0;
    c_addr    = '0;
    c_data    = '0;
    c_strb    = '0;
    e_rdata   = '0;
    e_err     = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_wr[i]   = 1'b0;
      p_addr[i] = '0;
      p_data[i] = '0;
      p_strb[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge pclk);
    #2;
    chk("reset_gnt", req_gnt, '0);
    chk("reset_done", req_done, '0);
    chk("reset_ctrl", {psel, penable, pwrite, rsp_err}, '0);
    chk("reset_paddr", paddr, '0);
    chk("reset_pstrb", pstrb, '0);
    chk("reset_rdata", rsp_rdata, '0);
    req_valid = '0;
    #1 preset = 1'b0;

    for (int r = 0; r < 3; r++) begin
      repeat (200) step();
      rst_mid();
    end

    fill_all = 1'b1;
    repeat (300) step();
    fill_all = 1'b0;

`ifdef APB_TIMEOUT_EN
    stall    = 1'b1;
    fill_all = 1'b1;
    repeat (80) step();
    stall    = 1'b0;
    fill_all = 1'b0;
`endif

    repeat (200) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
